issue_queue_request_tracker: RTL
================================

# issue_queue_request_tracker

Per-entry state keeper on the issue queue side of the wakeup/select loop. It produces the `opReady` vector and the per-class issue-request vectors that the select pickers consume. It consumes the pickers' one-hot grant vectors and tracks each entry through dispatch, wakeup, issue and release. One instance sits beside the issue queue payload RAM, between the dispatch stage, the wakeup tag broadcast and the select logic.

## Interface
Parameters:
- ENTRY_NUM, 16, issue queue entries; index width IDX_W = clog2(ENTRY_NUM)
- SRC_NUM, 2, source operands per entry
- TAG_W, 6, physical register tag width
- DISPATCH_WIDTH, 2, entries written per cycle
- WAKEUP_WIDTH, 4, tag broadcasts per cycle
- GRANT_NUM, 5, issue ports; grant vectors are OR-reduced
- ISSUE_HOLD, 2, cycles an issued entry is held for possible cancel before release (1..7)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- dispValid  in  DISPATCH_WIDTH  dispatch write enable per slot
- dispPtr  in  DISPATCH_WIDTH x IDX_W  target entry
- dispSrcTag  in  DISPATCH_WIDTH x SRC_NUM x TAG_W  source tags
- dispSrcReady  in  DISPATCH_WIDTH x SRC_NUM  source already ready at rename
- dispClass  in  DISPATCH_WIDTH x 2  0=int, 1=complex, 2=load, 3=store
- wakeupValid  in  WAKEUP_WIDTH  broadcast valid
- wakeupTag  in  WAKEUP_WIDTH x TAG_W  broadcast tag
- selectedVector  in  GRANT_NUM x ENTRY_NUM  one-hot grant per issue port
- cancelVector  in  ENTRY_NUM  re-arm issued entries (replay)
- flushVector  in  ENTRY_NUM  invalidate entries
- opReady  out  ENTRY_NUM  all sources ready and entry waiting
- intIssueReq, complexIssueReq, loadIssueReq, storeIssueReq  out  ENTRY_NUM  class-decoded request vectors
- releaseVector  out  ENTRY_NUM  one-cycle pulse when an entry becomes free
- protocolError  out  1  sticky illegal-event flag

## Operation
- Per-entry FSM: EMPTY, WAIT, ISSUED. Per-entry registers: src tags, SRC_NUM ready bits, 2-bit class, hold counter of 3 bits.
- EMPTY→WAIT on dispatch. Ready bit i = dispSrcReady[i] OR (dispSrcTag[i] matches any valid wakeupTag in the same cycle).
- In WAIT, a source ready bit is set when any valid wakeupTag equals its tag. Ready bits never clear in WAIT.
- opReady[e] = state==WAIT AND all ready bits set; all outputs are driven from registers. Each classReq[e] = state!=EMPTY AND class match. Unlike opReady, classReq does not require readiness; the select logic ANDs the two.
- A grant is the OR over the GRANT_NUM grant vectors. Granted entry in WAIT with opReady=1 → ISSUED, counter loaded with ISSUE_HOLD.
- In ISSUED, the counter decrements each cycle; counter==1 → EMPTY, with releaseVector[e] pulsed in the cycle the state becomes EMPTY.
- cancelVector[e] while ISSUED → WAIT, keeping its ready bits, so it re-requests the next cycle. Cancel in the expiry cycle wins: no release.
- flushVector[e] → EMPTY from any state, with no release pulse. Flush has priority over dispatch, cancel, grant and wakeup.
- Illegal events set protocolError, which only rst_n clears:
  - grant to an entry that is not WAIT+opReady (grant ignored)
  - dispatch to a non-EMPTY entry (write ignored unless the same cycle frees it by flush)
  - two dispatch slots naming the same entry (slot 0 wins)
  - cancel to a non-ISSUED entry (ignored)

## Timing
- Reset: all entries EMPTY; counters 0; opReady, all request vectors, releaseVector and protocolError are 0.
- Dispatch in cycle t → classReq visible at t+1; opReady visible at t+1 if ready at dispatch.
- Wakeup in cycle t → opReady at t+1 (one-cycle wakeup-to-select loop).
- Grant in cycle t → opReady low at t+1; release pulse at t+ISSUE_HOLD with ISSUE_HOLD=1, i.e. the state is EMPTY from t+ISSUE_HOLD.
- Cancel in cycle t → opReady high at t+1.
- Reset asserted mid-operation clears all state at the next edge; inputs are ignored while rst_n=0.
- Dispatch to an entry flushed the same cycle is accepted.

## Test plan
- Dispatch entry 3, class load, srcReady=11 → at t+1 opReady[3]=1 and loadIssueReq[3]=1; all other request vectors 0.
- Dispatch entry 5 with src tags 0x12/0x20, ready=00; wakeup 0x12 at t+2 and 0x20 at t+4 → opReady[5] rises at t+5, not earlier. Repeat with the tag broadcast in the dispatch cycle → opReady at t+1.
- Grant entry 5 at t, ISSUE_HOLD=2 → opReady[5]=0 at t+1, releaseVector[5]=1 exactly at t+2, entry EMPTY.
- Grant entry 7 at t, cancel at t+1 (the expiry cycle) → no release pulse, opReady[7]=1 at t+2; a regrant then releases normally.
- Flush entry 2 in WAIT while dispatch targets entry 2 in the same cycle → new contents accepted, no release pulse, protocolError=0. Grant to EMPTY entry 9 → protocolError=1 and stays 1 until rst_n.
- Fill all 16 entries, assert rst_n=0 for one cycle mid-stream → every output 0 the following cycle.

Source files
------------

// File: rtl/issue_queue_request_tracker.sv
// issue_queue_request_tracker
//
// Per-entry state keeper for the issue queue side of the wakeup/select loop.
// Every entry runs a small EMPTY -> WAIT -> ISSUED machine. The block turns
// dispatch writes, tag broadcasts, select grants, replay cancels and flushes
// into registered request vectors for the select pickers.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   dispValid/Ptr/...  up to DISPATCH_WIDTH entry writes per cycle (slot 0 wins on a clash)
//   wakeupValid/Tag    WAKEUP_WIDTH result-tag broadcasts per cycle
//   selectedVector     GRANT_NUM one-hot grant vectors, OR-reduced
//   cancelVector       send ISSUED entries back to WAIT (replay)
//   flushVector        drop entries to EMPTY, no release pulse
//   opReady            entry is WAIT with every source ready
//   *IssueReq          entry is occupied and holds that class (readiness not included)
//   releaseVector      one-cycle pulse when an issued entry retires to EMPTY
//   protocolError      sticky flag for illegal grant/dispatch/cancel events
module issue_queue_request_tracker #(
  parameter int ENTRY_NUM      = 16,
  parameter int SRC_NUM        = 2,
  parameter int TAG_W          = 6,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WAKEUP_WIDTH   = 4,
  parameter int GRANT_NUM      = 5,
  parameter int ISSUE_HOLD     = 2,
  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [DISPATCH_WIDTH-1:0]                         dispValid,
  input  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]              dispPtr,
  input  logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0][TAG_W-1:0] dispSrcTag,
  input  logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0]            dispSrcReady,
  input  logic [DISPATCH_WIDTH-1:0][1:0]                    dispClass,
  input  logic [WAKEUP_WIDTH-1:0]                           wakeupValid,
  input  logic [WAKEUP_WIDTH-1:0][TAG_W-1:0]                wakeupTag,
  input  logic [GRANT_NUM-1:0][ENTRY_NUM-1:0]               selectedVector,
  input  logic [ENTRY_NUM-1:0]                              cancelVector,
  input  logic [ENTRY_NUM-1:0]                              flushVector,
  output logic [ENTRY_NUM-1:0]                              opReady,
  output logic [ENTRY_NUM-1:0]                              intIssueReq,
  output logic [ENTRY_NUM-1:0]                              complexIssueReq,
  output logic [ENTRY_NUM-1:0]                              loadIssueReq,
  output logic [ENTRY_NUM-1:0]                              storeIssueReq,
  output logic [ENTRY_NUM-1:0]                              releaseVector,
  output logic                                              protocolError
);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_ISSUED} state_e;

  logic [ENTRY_NUM-1:0]                    grant_any;
  logic                                    disp_dup;
  logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0]  disp_rdy;
  logic [ENTRY_NUM-1:0]                    entry_err;
  logic                                    perr_q;

  always_comb begin
    grant_any = '0;
    for (int g = 0; g < GRANT_NUM; g++) grant_any = grant_any | selectedVector[g];
  end

  // Two valid slots naming the same entry is illegal; the per-entry pick below lets slot 0 win.
  always_comb begin
    disp_dup = 1'b0;
    for (int a = 0; a < DISPATCH_WIDTH; a++)
      for (int b = a + 1; b < DISPATCH_WIDTH; b++)
        if (dispValid[a] && dispValid[b] && (dispPtr[a] == dispPtr[b])) disp_dup = 1'b1;
  end

  // A source is ready at dispatch if rename said so or its producer broadcasts this cycle.
  always_comb begin
    disp_rdy = dispSrcReady;
    for (int d = 0; d < DISPATCH_WIDTH; d++)
      for (int s = 0; s < SRC_NUM; s++)
        for (int w = 0; w < WAKEUP_WIDTH; w++)
          if (wakeupValid[w] && (wakeupTag[w] == dispSrcTag[d][s])) disp_rdy[d][s] = 1'b1;
  end

  for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
    state_e                       state_q, state_d;
    logic [SRC_NUM-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SRC_NUM-1:0]           rdy_q, rdy_d;
    logic [1:0]                   cls_q, cls_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic                         op_q, op_d;
    logic [3:0]                   req_q, req_d;
    logic                         rel_q, rel_d;
    logic                         err_d;
    logic                         sel_vld;
    logic [SRC_NUM-1:0][TAG_W-1:0] sel_tag;
    logic [SRC_NUM-1:0]           sel_rdy;
    logic [1:0]                   sel_cls;
    logic [SRC_NUM-1:0]           wake_hit;

    // Scan slots from high to low so the lowest-numbered slot overrides.
    always_comb begin
      sel_vld = 1'b0;
      sel_tag = '0;
      sel_rdy = '0;
      sel_cls = '0;
      for (int d = DISPATCH_WIDTH - 1; d >= 0; d--) begin
        if (dispValid[d] && (dispPtr[d] == IDX_W'(gi))) begin
          sel_vld = 1'b1;
          sel_tag = dispSrcTag[d];
          sel_rdy = disp_rdy[d];
          sel_cls = dispClass[d];
        end
      end
    end

    always_comb begin
      wake_hit = '0;
      for (int s = 0; s < SRC_NUM; s++)
        for (int w = 0; w < WAKEUP_WIDTH; w++)
          if (wakeupValid[w] && (wakeupTag[w] == tag_q[s])) wake_hit[s] = 1'b1;
    end

    always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      rdy_d   = rdy_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      rel_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
        ST_WAIT: begin
          rdy_d = rdy_q | wake_hit;
          if (grant_any[gi]) begin
            if (op_q) begin
              if (ISSUE_HOLD <= 1) begin
                state_d = ST_EMPTY;
                rel_d   = 1'b1;
              end else begin
                state_d = ST_ISSUED;
                cnt_d   = 3'(ISSUE_HOLD);
              end
            end else begin
              err_d = 1'b1;
            end
          end
          if (cancelVector[gi]) err_d = 1'b1;
        end
        ST_ISSUED: begin
          if (grant_any[gi]) err_d = 1'b1;
          if (cancelVector[gi]) begin
            state_d = ST_WAIT;
          end else begin
            // The grant cycle is the first hold cycle, so the entry leaves
            // once the decremented count would reach 1.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd2) begin
              state_d = ST_EMPTY;
              cnt_d   = 3'd0;
              rel_d   = 1'b1;
            end
          end
        end
        default: begin
          if (grant_any[gi] || cancelVector[gi]) err_d = 1'b1;
        end
      endcase
      if (flushVector[gi]) begin
        state_d = ST_EMPTY;
        cnt_d   = 3'd0;
        rel_d   = 1'b0;
      end
      // A slot freed by flush in this cycle may be rewritten immediately.
      if (sel_vld) begin
        if ((state_q == ST_EMPTY) || flushVector[gi]) begin
          state_d = ST_WAIT;
          tag_d   = sel_tag;
          rdy_d   = sel_rdy;
          cls_d   = sel_cls;
          cnt_d   = 3'd0;
        end else begin
          err_d = 1'b1;
        end
      end
      op_d = (state_d == ST_WAIT) && (&rdy_d);
      for (int k = 0; k < 4; k++) req_d[k] = (state_d != ST_EMPTY) && (cls_d == 2'(k));
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        tag_q   <= '0;
        rdy_q   <= '0;
        cls_q   <= '0;
        cnt_q   <= '0;
        op_q    <= 1'b0;
        req_q   <= '0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        tag_q   <= tag_d;
        rdy_q   <= rdy_d;
        cls_q   <= cls_d;
        cnt_q   <= cnt_d;
        op_q    <= op_d;
        req_q   <= req_d;
        rel_q   <= rel_d;
      end
    end

    assign entry_err[gi]       = err_d;
    assign opReady[gi]         = op_q;
    assign intIssueReq[gi]     = req_q[0];
    assign complexIssueReq[gi] = req_q[1];
    assign loadIssueReq[gi]    = req_q[2];
    assign storeIssueReq[gi]   = req_q[3];
    assign releaseVector[gi]   = rel_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        perr_q <= 1'b0;
    else if (disp_dup || |entry_err)   perr_q <= 1'b1;
  end

  assign protocolError = perr_q;

endmodule
